// File: rtl/rmon_pkg.sv
// Shared types and default widths for the RMON statistics update path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rmon_pkg;

    localparam int RMON_ADDR_W = 6;
    localparam int RMON_DATA_W = 32;
    localparam int RMON_INCR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } rmon_state_e;

endpackage

// File: rtl/rmon_rr_arb.sv
// Two-way round-robin arbiter; req[0] is Tx, req[1] is Rx.
// Latency: combinational grant; pointer updates on the clock after a grant.
// Backpressure: losers are simply not granted and keep requesting.
module rmon_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr names the source that wins a tie; 0 (Tx) out of reset
    logic ptr;

    // Favoured source first, otherwise whichever one is requesting
    always_comb begin
        grant = 2'b00;
        if (req[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (req[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

    // After any grant the tie goes to the source that was not served
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/rmon_update_arbiter.sv
// RMON counter RAM port A read-modify-write sequencer: Tx/Rx round-robin, optional CPU clear under RMON_CPU_CLEAR_EN.
// Latency: ack in the grant cycle; increment written 3 cycles later (4 cycles per update), clear written the next cycle.
// Backpressure: no grant while an update is in flight; requesters hold req until ack, nothing is dropped.
module rmon_update_arbiter
    import rmon_pkg::*;
#(
    parameter int ADDR_W = RMON_ADDR_W,
    parameter int DATA_W = RMON_DATA_W,
    parameter int INCR_W = RMON_INCR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [INCR_W-1:0] tx_incr,
    output logic              tx_ack,
    input  logic              rx_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [INCR_W-1:0] rx_incr,
    output logic              rx_ack,
    input  logic              cpu_clr_req,
    input  logic [ADDR_W-1:0] cpu_clr_addr,
    output logic              cpu_clr_ack,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_wea,
    input  logic [DATA_W-1:0] ram_douta,
    output logic              busy
);

    rmon_state_e       state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [INCR_W-1:0] incr_q;
    logic [DATA_W-1:0] sum_q;
    logic              accept;
    logic              clr_take;
    logic              clr_gnt;
    logic [1:0]        arb_req;
    logic [1:0]        grant;

    // New work is only taken in IDLE, and never in a reset cycle so no ack is lost
    assign accept = (state == IDLE) && !Reset;

`ifdef RMON_CPU_CLEAR_EN
    assign clr_take = cpu_clr_req;
`else
    logic unused_clr;
    assign unused_clr = ^{cpu_clr_req, cpu_clr_addr};
    assign clr_take   = 1'b0;
`endif

    // Clear has strict priority: it masks both statistics sources
    assign clr_gnt = accept && clr_take;
    assign arb_req = {rx_req, tx_req} & {2{accept && !clr_take}};

    rmon_rr_arb u_arb (
        .clk     (Clk),
        .reset   (Reset),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant)
    );

    assign tx_ack      = grant[0];
    assign rx_ack      = grant[1];
    assign cpu_clr_ack = clr_gnt;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: increments go READ/WAIT/WRITE, clears go straight to WRITE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr_gnt) begin
                    state_nxt = WRITE;
                end else if (|grant) begin
                    state_nxt = READ;
                end
            end
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner at grant time and the incremented count at the end of WAIT
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q <= '0;
            incr_q <= '0;
            sum_q  <= '0;
        end else if (clr_gnt) begin
            addr_q <= cpu_clr_addr;
            incr_q <= '0;
            sum_q  <= '0;
        end else if (grant[0]) begin
            addr_q <= tx_addr;
            incr_q <= tx_incr;
        end else if (grant[1]) begin
            addr_q <= rx_addr;
            incr_q <= rx_incr;
        end else if (state == WAIT) begin
            sum_q <= ram_douta + DATA_W'(incr_q);
        end
    end

    // Port A is idle (all zero) in IDLE; a reset in WRITE suppresses the write
    assign ram_addra = (state == IDLE) ? '0 : addr_q;
    assign ram_dina  = (state == WRITE) ? sum_q : '0;
    assign ram_wea   = (state == WRITE) && !Reset;

    // The grant cycle counts as busy so the whole update window reads high
    assign busy = (state != IDLE) || (|grant) || clr_gnt;

endmodule

// File: tb/tb_rmon_update_arbiter.sv
// Self-checking bench for rmon_update_arbiter: vector table, corner-case sequences, randomized traffic vs. a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rmon_update_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        tx_req = 1'b0;
    logic [5:0]  tx_addr = '0;
    logic [15:0] tx_incr = '0;
    logic        tx_ack;
    logic        rx_req = 1'b0;
    logic [5:0]  rx_addr = '0;
    logic [15:0] rx_incr = '0;
    logic        rx_ack;
    logic        cpu_clr_req = 1'b0;
    logic [5:0]  cpu_clr_addr = '0;
    logic        cpu_clr_ack;
    logic [5:0]  ram_addra;
    logic [31:0] ram_dina;
    logic        ram_wea;
    logic [31:0] ram_douta;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    rmon_update_arbiter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .tx_req       (tx_req),
        .tx_addr      (tx_addr),
        .tx_incr      (tx_incr),
        .tx_ack       (tx_ack),
        .rx_req       (rx_req),
        .rx_addr      (rx_addr),
        .rx_incr      (rx_incr),
        .rx_ack       (rx_ack),
        .cpu_clr_req  (cpu_clr_req),
        .cpu_clr_addr (cpu_clr_addr),
        .cpu_clr_ack  (cpu_clr_ack),
        .ram_addra    (ram_addra),
        .ram_dina     (ram_dina),
        .ram_wea      (ram_wea),
        .ram_douta    (ram_douta),
        .busy         (busy)
    );

    // Statistics RAM port A with a bench-side preload port
    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_dat = '0;

    always @(posedge Clk) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        else if (ram_wea) mem[ram_addra] <= ram_dina;
        ram_douta <= mem[ram_addra];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        tick();
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1; tx_req = 1'b0; rx_req = 1'b0; cpu_clr_req = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic drive_src(input int src, input logic on, input logic [5:0] a, input logic [15:0] i);
        if (src == 0) begin
            tx_req = on; tx_addr = a; tx_incr = i;
        end else begin
            rx_req = on; rx_addr = a; rx_incr = i;
        end
    endtask

    typedef struct {
        int          src;
        logic [5:0]  addr;
        logic [15:0] incr;
        logic [31:0] init;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt [6];

    // Reset pulse in cycle rc (2 = WAIT, 3 = WRITE) of a Tx update: no write, all quiet afterwards
    task automatic reset_mid(input int rc, input logic [5:0] a, input logic [15:0] inc, input logic [31:0] init);
        preload(a, init);
        tick(); drive_src(0, 1'b1, a, inc);
        smp();  chk1("rst_mid_ack", tx_ack, 1'b1);
        for (int c = 1; c <= rc; c++) begin
            tick(); tx_req = 1'b0; Reset = (c == rc);
            smp();  chk1("rst_mid_no_wea", ram_wea, 1'b0);
        end
        tick(); Reset = 1'b0;
        smp();
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_wea", ram_wea, 1'b0);
        chk32("rst_mid_addra", 32'(ram_addra), 32'h0);
        chk32("rst_mid_dina", ram_dina, 32'h0);
        chk1("rst_mid_tx_ack", tx_ack, 1'b0);
        chk1("rst_mid_rx_ack", rx_ack, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick(); smp();
            chk1("rst_mid_idle_wea", ram_wea, 1'b0);
        end
        chk32("rst_mid_mem", mem[a], init);
    endtask

    initial begin
        logic [31:0] ref_mem [64];
        int          seq [$];
        int          tx_n, clr_acks, clr_writes;
        bit          rx_done;

        // Reset values
        tick(); smp();
        chk1("rst_tx_ack", tx_ack, 1'b0);
        chk1("rst_rx_ack", rx_ack, 1'b0);
        chk1("rst_clr_ack", cpu_clr_ack, 1'b0);
        chk1("rst_wea", ram_wea, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_addra", 32'(ram_addra), 32'h0);
        chk32("rst_dina", ram_dina, 32'h0);

        for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
        do_reset();

        // Single-source updates: {src, addr, incr, initial RAM, expected write data}
        vt[0] = '{0, 6'd5,  16'd3,      32'd10,         32'd13};
        vt[1] = '{1, 6'd3,  16'd2,      32'hFFFF_FFFF,  32'h0000_0001};
        vt[2] = '{0, 6'd63, 16'hFFFF,   32'h0,          32'h0000_FFFF};
        vt[3] = '{1, 6'd0,  16'd0,      32'd7,          32'd7};
        vt[4] = '{0, 6'd16, 16'd1,      32'hFFFF_FFFF,  32'h0};
        vt[5] = '{1, 6'd40, 16'h8000,   32'h1234_0000,  32'h1234_8000};

        for (int v = 0; v < 6; v++) begin
            preload(vt[v].addr, vt[v].init);
            tick(); drive_src(vt[v].src, 1'b1, vt[v].addr, vt[v].incr);
            smp();
            chk1("vec_ack", (vt[v].src == 0) ? tx_ack : rx_ack, 1'b1);
            chk1("vec_other_ack", (vt[v].src == 0) ? rx_ack : tx_ack, 1'b0);
            chk1("vec_busy0", busy, 1'b1);
            chk1("vec_wea0", ram_wea, 1'b0);
            for (int c = 1; c <= 3; c++) begin
                tick(); drive_src(vt[v].src, 1'b0, vt[v].addr, vt[v].incr);
                smp();
                chk1("vec_busy", busy, 1'b1);
                chk1("vec_wea", ram_wea, c == 3);
                if (c == 3) begin
                    chk32("vec_dina", ram_dina, vt[v].exp_dat);
                    chk32("vec_addra", 32'(ram_addra), 32'(vt[v].addr));
                end
            end
            tick(); smp();
            chk1("vec_busy4", busy, 1'b0);
            chk1("vec_wea4", ram_wea, 1'b0);
            chk32("vec_mem", mem[vt[v].addr], vt[v].exp_dat);
        end

        // Tx and Rx together after reset: Tx first, Rx four cycles later
        do_reset();
        preload(6'd1, 32'd50);
        preload(6'd2, 32'd60);
        tick(); drive_src(0, 1'b1, 6'd1, 16'd1); drive_src(1, 1'b1, 6'd2, 16'd2);
        smp();  chk1("tie_tx_ack", tx_ack, 1'b1); chk1("tie_rx_ack0", rx_ack, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick(); tx_req = 1'b0;
            smp();  chk1("tie_rx_ack", rx_ack, c == 4);
        end
        for (int c = 5; c <= 8; c++) begin
            tick(); rx_req = 1'b0;
            smp();
        end
        chk32("tie_mem1", mem[1], 32'd51);
        chk32("tie_mem2", mem[2], 32'd62);

        // Tx held continuously, one Rx request: grants alternate, Rx not starved
        do_reset();
        preload(6'd7, 32'd0);
        preload(6'd8, 32'd0);
        tx_n = 0; rx_done = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            drive_src(0, tx_n < 3, 6'd7, 16'd1);
            drive_src(1, !rx_done, 6'd8, 16'd1);
            smp();
            if (tx_ack) begin seq.push_back(0); tx_n++; end
            if (rx_ack) begin seq.push_back(1); rx_done = 1; end
        end
        chk32("alt_count", 32'(seq.size()), 32'd4);
        if (seq.size() == 4) begin
            chk32("alt_g0", 32'(seq[0]), 32'd0);
            chk32("alt_g1", 32'(seq[1]), 32'd1);
            chk32("alt_g2", 32'(seq[2]), 32'd0);
        end
        chk32("alt_mem7", mem[7], 32'd3);
        chk32("alt_mem8", mem[8], 32'd1);

        // Clear and Tx requested together
        do_reset();
        preload(6'd4, 32'h1234);
        preload(6'd9, 32'd5);
        clr_acks = 0; clr_writes = 0;
`ifdef RMON_CPU_CLEAR_EN
        tick(); cpu_clr_req = 1'b1; cpu_clr_addr = 6'd4; drive_src(0, 1'b1, 6'd9, 16'd1);
        smp();  chk1("clr_ack", cpu_clr_ack, 1'b1); chk1("clr_tx_ack0", tx_ack, 1'b0);
        tick(); cpu_clr_req = 1'b0;
        smp();
        chk1("clr_wea", ram_wea, 1'b1);
        chk32("clr_addra", 32'(ram_addra), 32'd4);
        chk32("clr_dina", ram_dina, 32'h0);
        chk1("clr_tx_ack1", tx_ack, 1'b0);
        tick(); smp(); chk1("clr_tx_ack2", tx_ack, 1'b1);
        for (int c = 3; c <= 6; c++) begin
            tick(); tx_req = 1'b0;
            smp();
        end
        chk32("clr_mem4", mem[4], 32'h0);
        chk32("clr_mem9", mem[9], 32'd6);
`else
        for (int c = 0; c < 10; c++) begin
            tick();
            cpu_clr_req = 1'b1; cpu_clr_addr = 6'd4;
            drive_src(0, c == 0, 6'd9, 16'd1);
            smp();
            if (cpu_clr_ack) clr_acks++;
            if (ram_wea && ram_addra == 6'd4) clr_writes++;
            if (c == 0) chk1("noclr_tx_ack", tx_ack, 1'b1);
            if (c == 3) chk1("noclr_tx_wea", ram_wea, 1'b1);
        end
        tick(); cpu_clr_req = 1'b0;
        chk32("noclr_acks", 32'(clr_acks), 32'd0);
        chk32("noclr_writes", 32'(clr_writes), 32'd0);
        chk32("noclr_mem4", mem[4], 32'h1234);
        chk32("noclr_mem9", mem[9], 32'd6);
`endif

        // Reset in the WAIT cycle, then in the WRITE cycle
        do_reset();
        reset_mid(2, 6'd6, 16'd5, 32'd100);
        reset_mid(3, 6'd11, 16'd9, 32'd200);

        // Randomized Tx/Rx traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 8; i++) preload(6'(i), 32'hFFFF_FF00 + 32'(i * 40));
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        begin
            bit          pend [2];
            logic [5:0]  pa [2];
            logic [15:0] pi [2];
            int          since, last, g;
            logic [5:0]  wa;
            logic [31:0] wd;
            pend[0] = 0; pend[1] = 0; pa[0] = '0; pa[1] = '0; pi[0] = '0; pi[1] = '0;
            since = 100; last = 1; wa = '0; wd = '0;
            for (int c = 0; c < 3000; c++) begin
                tick();
                for (int s = 0; s < 2; s++) begin
                    if (!pend[s] && $urandom_range(0, 2) == 0) begin
                        pend[s] = 1;
                        pa[s] = 6'($urandom_range(0, 9));
                        pi[s] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    end
                    drive_src(s, pend[s], pa[s], pi[s]);
                end
                smp();
                since++;
                g = -1;
                if (since >= 4) begin
                    if (pend[0] && pend[1]) g = (last == 0) ? 1 : 0;
                    else if (pend[0]) g = 0;
                    else if (pend[1]) g = 1;
                end
                chk1("rnd_tx_ack", tx_ack, g == 0);
                chk1("rnd_rx_ack", rx_ack, g == 1);
                if (g >= 0) begin
                    wa = pa[g];
                    wd = ref_mem[pa[g]] + 32'(pi[g]);
                    ref_mem[pa[g]] = wd;
                    pend[g] = 0;
                    last = g;
                    since = 0;
                end
                chk1("rnd_wea", ram_wea, since == 3);
                if (since == 3) begin
                    chk32("rnd_addra", 32'(ram_addra), 32'(wa));
                    chk32("rnd_dina", ram_dina, wd);
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick(); tx_req = 1'b0; rx_req = 1'b0;
            smp();
        end
        for (int i = 0; i < 64; i++) chk32("rnd_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmon_update_arbiter.md
# rmon_update_arbiter

Read-modify-write controller for the RMON statistics RAM. Accepts counter-increment requests from the Tx and Rx statistics sources, arbitrates round-robin between them, and sequences each update on RAM port A: read, wait one cycle, write back the incremented value. The CPU keeps its direct read path on port B. This block is the only agent that drives port A.

## Interface
Parameters:
- ADDR_W, 6, counter address width (64 counters)
- DATA_W, 32, counter width
- INCR_W, 16, increment width, zero-extended to DATA_W

Ports:
- Clk  in  1  single clock
- Reset  in  1  synchronous, active-high reset
- tx_req  in  1  Tx update request, held until tx_ack
- tx_addr  in  ADDR_W  Tx counter address
- tx_incr  in  INCR_W  Tx increment
- tx_ack  out  1  one-cycle pulse: Tx request accepted
- rx_req, rx_addr, rx_incr, rx_ack  same as the Tx group, for Rx
- cpu_clr_req  in  1  CPU clear request, held until cpu_clr_ack
- cpu_clr_addr  in  ADDR_W  counter to zero
- cpu_clr_ack  out  1  one-cycle pulse: clear accepted
- ram_addra  out  ADDR_W  port A address
- ram_dina  out  DATA_W  port A write data
- ram_wea  out  1  port A write enable
- ram_douta  in  DATA_W  port A read data, valid one cycle after address
- busy  out  1  high whenever the state is not IDLE

## Operation
- States are IDLE, READ, WAIT, WRITE.
- IDLE:
  - If a request is pending, grant it, latch its addr and incr, pulse its ack in the same cycle, and go to READ.
  - A clear grant goes directly to WRITE with data 0.
- READ: drive ram_addra with the latched address, then go to WAIT.
- WAIT: hold ram_addra. At the end of the cycle, capture sum = ram_douta + zero-extended incr, then go to WRITE.
- WRITE: drive ram_wea=1, ram_addra with the latched address, and ram_dina with sum (or 0 for a clear). Return to IDLE.
- Arithmetic wraps modulo 2^DATA_W. 0xFFFFFFFF + 1 gives 0. No saturation.
- Arbitration:
  - Clear (when compiled in) has strict priority.
  - Tx and Rx alternate round-robin. The pointer moves to the other source after each Tx or Rx grant.
  - After reset, Tx wins a tie.
- Updates are fully serialized. A back-to-back update to the same address always sees the prior write, so there is no forwarding or hazard logic.
- A requester that is not granted keeps req high. Its addr and incr must stay stable until its ack.
- ram_wea is asserted only in WRITE.

## Timing
- Reset values: state IDLE, tx_ack, rx_ack, cpu_clr_ack, ram_wea and busy all 0, ram_addra 0, ram_dina 0, RR pointer on Tx.
- Increment update: 4 cycles from the grant cycle to the write cycle inclusive. Maximum throughput is one update per 4 cycles.
- Clear: 2 cycles (IDLE, WRITE).
- The earliest next grant is the cycle after WRITE.
- Reset during READ, WAIT or WRITE:
  - The next state is IDLE.
  - The write is suppressed if Reset is high in the WRITE cycle.
  - The already-acked update is lost.
  - No ack is re-issued.
- Requests that arrive while busy wait. They are never dropped.

## Configuration
- RMON_CPU_CLEAR_EN defined: the clear path is active with strict priority, as described above.
- RMON_CPU_CLEAR_EN undefined:
  - cpu_clr_req and cpu_clr_addr are ignored.
  - cpu_clr_ack is tied to 0.
  - The IDLE to WRITE clear transition is removed.
- The ports exist in both builds.

## Structure
- Shared package rmon_pkg holds:
  - the state enumeration (IDLE, READ, WAIT, WRITE)
  - the default width constants RMON_ADDR_W=6, RMON_DATA_W=32 and RMON_INCR_W=16
- Sub-module rmon_rr_arb implements the 2-way round-robin arbiter. It has req[1:0], an advance strobe, grant[1:0] and the pointer register.
- The FSM, latches and adder live in the top module.

## Test plan
- Single Tx update, addr 5, incr 3, RAM[5]=10:
  - tx_ack in cycle 0
  - ram_wea in cycle 3 with ram_dina 13
  - busy high for cycles 0 to 3
- Tx and Rx requests in the same cycle after reset (Tx addr 1, incr 1; Rx addr 2, incr 2):
  - Tx is granted first
  - Rx is granted in cycle 4
  - RAM[1] and RAM[2] each increase by their increments
- Tx held continuously to addr 7 with incr 1 while Rx requests addr 8:
  - grants alternate Tx, Rx, Tx
  - no starvation
- Wrap: RAM[3]=0xFFFFFFFF, incr 2 -> the written value is 0x00000001.
- With RMON_CPU_CLEAR_EN defined, clear addr 4 and Tx requested together:
  - the clear wins
  - ram_wea in the next cycle with data 0
  - Tx is granted 2 cycles after the clear grant
- Without the macro, the same clear request never produces an ack or a write.
- Reset asserted in the WAIT cycle of an update to addr 6:
  - no ram_wea
  - RAM[6] is unchanged
  - state is IDLE and all outputs are 0 in the next cycle
